// File: rtl/bubbledrive8_flasharb_if.sv
// bubbledrive8_flasharb_if: request/grant, SPI master and flash pins of the flash arbiter.
interface bubbledrive8_flasharb_if;
    logic n_en_i, n_emu_req_i, n_usb_req_i;
    logic emu_ncs_i, emu_clk_i, emu_mosi_i;
    logic usb_ncs_i, usb_clk_i, usb_mosi_i;
    logic romio1_i;
    logic n_emu_gnt_o, n_usb_gnt_o, emu_miso_o, usb_miso_o;
    logic rom_ncs_o, rom_clk_o, rom_io0_o, rom_io0_oe_o;
    logic usb_timeout_o, busy_o;
    modport slave (
        input  n_en_i, n_emu_req_i, n_usb_req_i, emu_ncs_i, emu_clk_i, emu_mosi_i,
               usb_ncs_i, usb_clk_i, usb_mosi_i, romio1_i,
        output n_emu_gnt_o, n_usb_gnt_o, emu_miso_o, usb_miso_o,
               rom_ncs_o, rom_clk_o, rom_io0_o, rom_io0_oe_o, usb_timeout_o, busy_o
    );
    modport master (
        output n_en_i, n_emu_req_i, n_usb_req_i, emu_ncs_i, emu_clk_i, emu_mosi_i,
               usb_ncs_i, usb_clk_i, usb_mosi_i, romio1_i,
        input  n_emu_gnt_o, n_usb_gnt_o, emu_miso_o, usb_miso_o,
               rom_ncs_o, rom_clk_o, rom_io0_o, rom_io0_oe_o, usb_timeout_o, busy_o
    );
endinterface

// File: rtl/bubbledrive8_flasharb.sv
// bubbledrive8_flasharb: non-preemptive SPI flash arbiter between emulator and USB masters,
// with a deselect guard between owners and an inactivity watchdog on the USB grant.
module bubbledrive8_flasharb #(
    parameter int unsigned GUARD_CYCLES = 8,
    parameter logic [23:0] USB_IDLE_MAX = 24'd4800000
) (
    input logic mclk_i,
    input logic nrst_i,
    bubbledrive8_flasharb_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, GNT_EMU = 2'd1, GNT_USB = 2'd2, GUARD = 2'd3;
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [23:0] WD_LAST = USB_IDLE_MAX - 24'd1;
    logic [1:0] state_q, state_d;
    logic [7:0] guard_q, guard_d;
    logic [23:0] wd_q, wd_d;
    logic lock_q, lock_d, usb_clk_q, usb_ncs_q;
    logic n_emu_gnt_q, n_usb_gnt_q, rom_ncs_q, rom_clk_q, rom_io0_q, rom_oe_q, usb_timeout_q;
    logic usb_act, wd_hit, emu_own, usb_own;
    always_comb begin
        usb_act = (bus.usb_clk_i != usb_clk_q) || (bus.usb_ncs_i != usb_ncs_q);
        wd_hit = (state_q == GNT_USB) && (wd_q == WD_LAST);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (!bus.n_en_i && !bus.n_emu_req_i) ? GNT_EMU :
                               (!bus.n_en_i && !bus.n_usb_req_i && !lock_q) ? GNT_USB : IDLE;
            GNT_EMU: state_d = (bus.n_emu_req_i || bus.n_en_i) ? GUARD : GNT_EMU;
            GNT_USB: state_d = (bus.n_usb_req_i || bus.n_en_i || wd_hit) ? GUARD : GNT_USB;
            default: state_d = (guard_q == 8'd0) ? IDLE : GUARD;
        endcase
        guard_d = (state_d == GUARD && state_q != GUARD) ? GUARD_LOAD :
                  (state_q == GUARD && guard_q != 8'd0) ? guard_q - 8'd1 : guard_q;
        wd_d = ((state_d == GNT_USB && state_q != GNT_USB) || usb_act) ? 24'd0 :
               (&wd_q) ? wd_q : wd_q + 24'd1;
        // a timed-out USB requester stays locked out until it drops its request
        lock_d = !bus.n_usb_req_i && (lock_q || wd_hit);
        emu_own = state_d == GNT_EMU;
        usb_own = state_d == GNT_USB;
    end
    always_ff @(posedge mclk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= IDLE;
            guard_q <= 8'd0;
            wd_q <= 24'd0;
            lock_q <= 1'b0;
            usb_clk_q <= 1'b1;
            usb_ncs_q <= 1'b1;
            n_emu_gnt_q <= 1'b1;
            n_usb_gnt_q <= 1'b1;
            rom_ncs_q <= 1'b1;
            rom_clk_q <= 1'b0;
            rom_io0_q <= 1'b0;
            rom_oe_q <= 1'b0;
            usb_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            wd_q <= wd_d;
            lock_q <= lock_d;
            usb_clk_q <= bus.usb_clk_i;
            usb_ncs_q <= bus.usb_ncs_i;
            n_emu_gnt_q <= !emu_own;
            n_usb_gnt_q <= !usb_own;
            rom_ncs_q <= emu_own ? bus.emu_ncs_i : usb_own ? bus.usb_ncs_i : 1'b1;
            rom_clk_q <= emu_own ? bus.emu_clk_i : usb_own ? bus.usb_clk_i : 1'b0;
            rom_io0_q <= emu_own ? bus.emu_mosi_i : usb_own ? bus.usb_mosi_i : 1'b0;
            rom_oe_q <= emu_own || usb_own;
            usb_timeout_q <= wd_hit;
        end
    end
    assign bus.n_emu_gnt_o = n_emu_gnt_q;
    assign bus.n_usb_gnt_o = n_usb_gnt_q;
    assign bus.rom_ncs_o = rom_ncs_q;
    assign bus.rom_clk_o = rom_clk_q;
    assign bus.rom_io0_o = rom_io0_q;
    assign bus.rom_io0_oe_o = rom_oe_q;
    assign bus.usb_timeout_o = usb_timeout_q;
    assign bus.busy_o = state_q != IDLE;
    assign bus.emu_miso_o = (state_q == GNT_EMU) ? bus.romio1_i : 1'b1;
    assign bus.usb_miso_o = (state_q == GNT_USB) ? bus.romio1_i : 1'b1;
endmodule

// File: tb/tb_bubbledrive8_flasharb.sv
// tb_bubbledrive8_flasharb: directed scoreboard bench; dut_a uses an 8-cycle guard and 16-cycle
// USB watchdog, dut_b a 1-cycle guard for back-to-back ownerships.
module tb_bubbledrive8_flasharb;
    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;
    bubbledrive8_flasharb_if ifa ();
    bubbledrive8_flasharb_if ifb ();
    bubbledrive8_flasharb #(.GUARD_CYCLES(8), .USB_IDLE_MAX(24'd16)) dut_a (
        .mclk_i(clk), .nrst_i(nrst), .bus(ifa.slave));
    bubbledrive8_flasharb #(.GUARD_CYCLES(1), .USB_IDLE_MAX(24'd16)) dut_b (
        .mclk_i(clk), .nrst_i(nrst), .bus(ifb.slave));
    typedef struct {
        string tag;
        logic [9:0] exp;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic rc, rm;
    logic [9:0] obs_a, obs_b;
    // {nEMUGNT, nUSBGNT, nROMCS, ROMCLK, ROMIO0_O, ROMIO0_OE, USBTIMEOUT, BUSY, EMU_MISO, USB_MISO}
    assign obs_a = {ifa.n_emu_gnt_o, ifa.n_usb_gnt_o, ifa.rom_ncs_o, ifa.rom_clk_o, ifa.rom_io0_o,
                    ifa.rom_io0_oe_o, ifa.usb_timeout_o, ifa.busy_o, ifa.emu_miso_o, ifa.usb_miso_o};
    assign obs_b = {ifb.n_emu_gnt_o, ifb.n_usb_gnt_o, ifb.rom_ncs_o, ifb.rom_clk_o, ifb.rom_io0_o,
                    ifb.rom_io0_oe_o, ifb.usb_timeout_o, ifb.busy_o, ifb.emu_miso_o, ifb.usb_miso_o};
    function automatic logic [9:0] v_idle();
        return 10'b1110000011;
    endfunction
    function automatic logic [9:0] v_guard(input logic to);
        return {3'b111, 3'b000, to, 1'b1, 2'b11};
    endfunction
    function automatic logic [9:0] v_emu(input logic ncs, input logic c, input logic m, input logic miso);
        return {1'b0, 1'b1, ncs, c, m, 1'b1, 1'b0, 1'b1, miso, 1'b1};
    endfunction
    function automatic logic [9:0] v_usb(input logic ncs, input logic c, input logic m, input logic miso);
        return {1'b1, 1'b0, ncs, c, m, 1'b1, 1'b0, 1'b1, 1'b1, miso};
    endfunction
    task automatic compare(input logic [9:0] o);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (o === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", e.tag, o, e.exp);
        end
    endtask
    task automatic now_a(input string tag, input logic [9:0] exp);
        sb.push_back('{tag, exp});
        compare(obs_a);
    endtask
    task automatic now_b(input string tag, input logic [9:0] exp);
        sb.push_back('{tag, exp});
        compare(obs_b);
    endtask
    task automatic step_a(input string tag, input logic [9:0] exp);
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1 compare(obs_a);
    endtask
    task automatic step_b(input string tag, input logic [9:0] exp);
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1 compare(obs_b);
    endtask
    initial begin
        ifa.n_en_i = 0; ifa.n_emu_req_i = 1; ifa.n_usb_req_i = 1; ifa.romio1_i = 1;
        ifa.emu_ncs_i = 1; ifa.emu_clk_i = 0; ifa.emu_mosi_i = 0;
        ifa.usb_ncs_i = 1; ifa.usb_clk_i = 0; ifa.usb_mosi_i = 0;
        ifb.n_en_i = 0; ifb.n_emu_req_i = 1; ifb.n_usb_req_i = 1; ifb.romio1_i = 1;
        ifb.emu_ncs_i = 1; ifb.emu_clk_i = 0; ifb.emu_mosi_i = 0;
        ifb.usb_ncs_i = 1; ifb.usb_clk_i = 0; ifb.usb_mosi_i = 0;
        #1 nrst = 0;
        #1 now_a("reset_a", v_idle());
        now_b("reset_b", v_idle());
        repeat (2) @(posedge clk);
        #1 nrst = 1;
        step_a("idle_after_reset", v_idle());
        ifa.n_emu_req_i = 0; ifa.n_usb_req_i = 0; ifa.emu_ncs_i = 0;
        step_a("simultaneous_emu_wins", v_emu(0, 0, 0, 1));
        rc = 0; rm = 0;
        for (int i = 0; i < 6; i++) begin
            ifa.emu_clk_i = ~ifa.emu_clk_i; ifa.emu_mosi_i = i[1]; ifa.romio1_i = i[0];
            #1 now_a("romclk_lag", v_emu(0, rc, rm, ifa.romio1_i));
            step_a("romclk_follow", v_emu(0, ifa.emu_clk_i, ifa.emu_mosi_i, ifa.romio1_i));
            rc = ifa.emu_clk_i; rm = ifa.emu_mosi_i;
        end
        ifa.emu_ncs_i = 1;
        step_a("emu_cs_release", v_emu(1, 0, 0, 1));
        ifa.n_emu_req_i = 1; ifa.usb_ncs_i = 0;
        step_a("guard_enter", v_guard(0));
        for (int i = 1; i < 8; i++) step_a("guard_hold", v_guard(0));
        step_a("idle_eval", v_idle());
        step_a("usb_after_guard", v_usb(0, 0, 0, 1));
        ifa.romio1_i = 0;
        for (int i = 1; i < 16; i++) step_a("usb_idle_wait", v_usb(0, 0, 0, 0));
        step_a("usb_timeout", v_guard(1));
        step_a("timeout_pulse_end", v_guard(0));
        for (int i = 2; i < 8; i++) step_a("timeout_guard", v_guard(0));
        for (int i = 0; i < 4; i++) step_a("lockout_idle", v_idle());
        ifa.n_usb_req_i = 1;
        step_a("usb_release", v_idle());
        ifa.n_usb_req_i = 0;
        step_a("usb_regrant", v_usb(0, 0, 0, 0));
        ifa.n_en_i = 1; ifa.n_emu_req_i = 0;
        step_a("nen_release", v_guard(0));
        for (int i = 1; i < 8; i++) step_a("nen_guard_full", v_guard(0));
        for (int i = 0; i < 3; i++) step_a("nen_blocks", v_idle());
        ifa.n_en_i = 0; ifa.emu_ncs_i = 0;
        step_a("nen_low_emu", v_emu(0, 0, 0, 0));
        #2 nrst = 0;
        #1 now_a("async_reset", v_idle());
        @(posedge clk);
        #1 now_a("reset_held", v_idle());
        nrst = 1;
        step_a("regrant_after_reset", v_emu(0, 0, 0, 0));
        ifb.n_emu_req_i = 0; ifb.emu_ncs_i = 0;
        step_b("b_grant", v_emu(0, 0, 0, 1));
        ifb.n_emu_req_i = 1;
        step_b("b_guard_one", v_guard(0));
        ifb.n_emu_req_i = 0;
        step_b("b_idle_eval", v_idle());
        step_b("b_regrant", v_emu(0, 0, 0, 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
